// File: rtl/uart_tx_queue_if.sv
// rtl/uart_tx_queue_if.sv - producer and UART-side signal bundle for uart_tx_queue
//
// Purpose: groups the byte-producer handshake, the flush control, the UART
//          request/idle pair and the status outputs of uart_tx_queue.
// Signals:
//   in_byte  [7:0]  byte offered by the producer
//   in_valid        in_byte is valid this cycle
//   in_ready        queue accepts in_byte this cycle
//   flush           synchronous discard of all queued bytes
//   tx_byte  [7:0]  byte presented to the UART transmitter
//   tx_req          one-cycle transmit request to the UART
//   tx_idle         UART transmitter is idle and samples tx_req
//   level           number of bytes currently queued
//   busy            queue non-empty or a byte in flight
// Modports:
//   master  producer / UART side (drives in_*, flush, tx_idle)
//   slave   the queue itself
interface uart_tx_queue_if #(
   parameter int DEPTH = 16
) ();
   logic [7:0]             in_byte;
   logic                   in_valid;
   logic                   in_ready;
   logic                   flush;
   logic [7:0]             tx_byte;
   logic                   tx_req;
   logic                   tx_idle;
   logic [$clog2(DEPTH):0] level;
   logic                   busy;

   modport master (
      output in_byte, in_valid, flush, tx_idle,
      input  in_ready, tx_byte, tx_req, level, busy
   );

   modport slave (
      input  in_byte, in_valid, flush, tx_idle,
      output in_ready, tx_byte, tx_req, level, busy
   );
endinterface

// File: rtl/uart_tx_queue.sv
// rtl/uart_tx_queue.sv - byte FIFO draining into a UART transmitter, one request per frame
//
// Purpose: buffers up to DEPTH bytes from a producer and hands them to a UART
//          transmitter in FIFO order, issuing a single-cycle tx_req only when
//          the transmitter is idle and then waiting for the whole frame
//          (tx_idle low, then high again) before the next byte is offered.
// Parameters:
//   DEPTH  FIFO capacity in bytes, power of two, >= 2
// Ports:
//   clk   rising-edge clock for all state
//   rst   asynchronous, active-high reset
//   port  uart_tx_queue_if.slave bundle (in_byte/in_valid/in_ready, flush,
//         tx_byte/tx_req/tx_idle, level, busy)
module uart_tx_queue #(
   parameter int DEPTH = 16
) (
   input logic            clk,
   input logic            rst,
   uart_tx_queue_if.slave port
);

   localparam int AW = $clog2(DEPTH);

   typedef enum logic [1:0] {
      S_IDLE,
      S_REQ,
      S_WAIT_BUSY,
      S_WAIT_DONE
   } state_t;

   state_t      state;
   state_t      state_next;

   logic [7:0]  mem [DEPTH];
   logic [AW:0] wr_ptr;
   logic [AW:0] rd_ptr;
   logic [AW:0] level_q;
   logic [7:0]  tx_byte_q;
   logic        tx_req_q;
   logic        head_ok;

   logic        empty;
   logic        full;
   logic        in_ready;
   logic        push;
   logic        pop;

   // Extra pointer MSB distinguishes full from empty when the index bits match.
   assign empty    = (wr_ptr == rd_ptr);
   assign full     = (wr_ptr[AW] != rd_ptr[AW]) &&
                     (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

   assign in_ready = !full && !port.flush;
   assign push     = port.in_valid && in_ready;

   // Drain FSM: next state and pop decision.
   always_comb begin
      state_next = state;
      pop        = 1'b0;
      case (state)
         S_IDLE: begin
            // head_ok delays the first look at a newly written byte by one
            // cycle; flush takes priority and keeps the FSM here.
            if (head_ok && !empty && port.tx_idle && !port.flush) begin
               pop        = 1'b1;
               state_next = S_REQ;
            end
         end
         S_REQ: begin
            state_next = S_WAIT_BUSY;
         end
         S_WAIT_BUSY: begin
            if (!port.tx_idle) begin
               state_next = S_WAIT_DONE;
            end
         end
         S_WAIT_DONE: begin
            if (port.tx_idle) begin
               state_next = S_IDLE;
            end
         end
         default: begin
            state_next = S_IDLE;
         end
      endcase
   end

   // FSM state register plus registered request/byte outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         tx_req_q  <= 1'b0;
         tx_byte_q <= 8'h00;
      end else begin
         state    <= state_next;
         // High exactly while the FSM sits in S_REQ.
         tx_req_q <= pop;
         if (pop) begin
            tx_byte_q <= mem[rd_ptr[AW-1:0]];
         end
      end
   end

   // Pointers and occupancy; flush overrides any same-edge push or pop.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         level_q <= '0;
         head_ok <= 1'b0;
      end else if (port.flush) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         level_q <= '0;
         head_ok <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   level_q <= level_q + 1'b1;
            2'b01:   level_q <= level_q - 1'b1;
            default: level_q <= level_q;
         endcase
         head_ok <= !empty;
      end
   end

   // Byte storage carries no reset; only the pointers define its contents.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr[AW-1:0]] <= port.in_byte;
      end
   end

   assign port.in_ready = in_ready;
   assign port.tx_req   = tx_req_q;
   assign port.tx_byte  = tx_byte_q;
   assign port.level    = level_q;
   assign port.busy     = (level_q != '0) || (state != S_IDLE);

endmodule

// File: tb/tb_uart_tx_queue.sv
// tb/tb_uart_tx_queue.sv - self-checking bench for uart_tx_queue
module tb_uart_tx_queue;

   localparam int DEPTH = 16;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   uart_tx_queue_if #(.DEPTH(DEPTH)) ifc ();

   uart_tx_queue #(.DEPTH(DEPTH)) dut (
      .clk  (clk),
      .rst  (rst),
      .port (ifc)
   );

   int         checks = 0;
   int         errors = 0;

   logic [7:0] mq[$];      // bytes the queue should currently hold, head first
   logic [7:0] txlog[$];   // every byte seen with tx_req, in order
   bit         frame_open;
   bit         frame_low;
   bit         req_pending;
   bit         prev_req;
   bit         last_acc;
   bit         uart_auto;
   bit         uart_rand;
   int         uart_cnt;
   int         uart_len;
   logic [7:0] last_tx;
   int         base;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock: check in_ready, predict the edge, then check the outputs.
   task automatic tick();
      bit         exp_ready;
      bit         acc;
      bit         fl;
      logic [7:0] b;
      #1;
      exp_ready = (mq.size() != DEPTH) && !ifc.flush;
      check("in_ready", ifc.in_ready, exp_ready);
      acc = ifc.in_valid && exp_ready;
      fl  = ifc.flush;
      b   = ifc.in_byte;
      if (frame_open) begin
         if (!ifc.tx_idle) frame_low = 1'b1;
         else if (frame_low) begin
            frame_open = 1'b0;
            frame_low  = 1'b0;
         end
      end
      @(posedge clk);
      #1;
      last_acc = acc;
      if (fl) mq.delete();
      else if (acc) mq.push_back(b);
      if (uart_auto) begin
         if (req_pending) begin
            ifc.tx_idle = 1'b0;
            uart_cnt = uart_rand ? int'($urandom_range(1, 8)) : uart_len;
         end else if (uart_cnt > 0) begin
            uart_cnt--;
            if (uart_cnt == 0) ifc.tx_idle = 1'b1;
         end
      end
      req_pending = 1'b0;
      if (ifc.tx_req === 1'b1) begin
         check("req_one_per_frame", frame_open, 0);
         check("req_back_to_back", prev_req, 0);
         check("req_queue_nonempty", mq.size() != 0, 1);
         if (mq.size() != 0) check("tx_byte_order", ifc.tx_byte, mq.pop_front());
         txlog.push_back(ifc.tx_byte);
         last_tx     = ifc.tx_byte;
         frame_open  = 1'b1;
         frame_low   = 1'b0;
         req_pending = 1'b1;
      end else begin
         check("tx_byte_hold", ifc.tx_byte, last_tx);
      end
      check("level", ifc.level, mq.size());
      if (mq.size() != 0) check("busy_nonempty", ifc.busy, 1);
      prev_req = ifc.tx_req;
   endtask

   task automatic push_byte(input logic [7:0] b);
      ifc.in_byte  = b;
      ifc.in_valid = 1'b1;
      for (int i = 0; i < 400; i++) begin
         tick();
         if (last_acc) break;
      end
      ifc.in_valid = 1'b0;
      check("push_accepted", last_acc, 1);
   endtask

   task automatic wait_idle(input int max);
      for (int i = 0; i < max; i++) begin
         if (ifc.busy === 1'b0 && mq.size() == 0) break;
         tick();
      end
      check("wait_idle_busy", ifc.busy, 0);
   endtask

   task automatic async_reset();
      #2;
      rst = 1'b1;
      #1;
      check("arst_tx_req", ifc.tx_req, 0);
      check("arst_level", ifc.level, 0);
      check("arst_busy", ifc.busy, 0);
      check("arst_tx_byte", ifc.tx_byte, 8'h00);
      mq.delete();
      frame_open  = 1'b0;
      frame_low   = 1'b0;
      req_pending = 1'b0;
      prev_req    = 1'b0;
      uart_cnt    = 0;
      last_tx     = 8'h00;
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      rst          = 1'b1;
      ifc.in_byte  = 8'h00;
      ifc.in_valid = 1'b0;
      ifc.flush    = 1'b0;
      ifc.tx_idle  = 1'b1;
      uart_auto    = 1'b0;
      uart_rand    = 1'b0;
      uart_len     = 3;
      uart_cnt     = 0;
      frame_open   = 1'b0;
      frame_low    = 1'b0;
      req_pending  = 1'b0;
      prev_req     = 1'b0;
      last_acc     = 1'b0;
      last_tx      = 8'h00;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check("reset_tx_req", ifc.tx_req, 0);
      check("reset_tx_byte", ifc.tx_byte, 8'h00);
      check("reset_level", ifc.level, 0);
      check("reset_busy", ifc.busy, 0);
      rst = 1'b0;
      tick();
      check("post_reset_ready", ifc.in_ready, 1);

      // Single byte and push-to-request latency
      uart_auto = 1'b1;
      push_byte(8'hA5);
      check("lat_n_req", ifc.tx_req, 0);
      check("lat_n_level", ifc.level, 1);
      tick();
      check("lat_n1_req", ifc.tx_req, 0);
      check("lat_n1_level", ifc.level, 1);
      tick();
      check("lat_n2_req", ifc.tx_req, 1);
      check("lat_n2_byte", ifc.tx_byte, 8'hA5);
      check("lat_n2_level", ifc.level, 0);
      tick();
      check("lat_n3_req", ifc.tx_req, 0);
      wait_idle(100);

      // Pacing against a slow transmitter
      uart_len = 100;
      base = txlog.size();
      push_byte(8'h01);
      push_byte(8'h02);
      push_byte(8'h03);
      wait_idle(1000);
      check("pace_count", txlog.size() - base, 3);
      check("pace_b0", txlog[base], 8'h01);
      check("pace_b1", txlog[base+1], 8'h02);
      check("pace_b2", txlog[base+2], 8'h03);
      uart_len = 3;

      // Full, stall and wrap
      uart_auto   = 1'b0;
      ifc.tx_idle = 1'b0;
      base = txlog.size();
      for (int i = 0; i < 16; i++) push_byte(8'(i));
      check("full_level", ifc.level, 16);
      ifc.in_byte  = 8'd16;
      ifc.in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("full_stall", last_acc, 0);
      end
      check("full_ready", ifc.in_ready, 0);
      check("full_level_hold", ifc.level, 16);
      uart_auto   = 1'b1;
      uart_cnt    = 0;
      ifc.tx_idle = 1'b1;
      push_byte(8'd16);
      wait_idle(500);
      check("wrap_count", txlog.size() - base, 17);
      for (int i = 0; i < 17; i++) check("wrap_order", txlog[base+i], 8'(i));

      // Simultaneous push and pop at level 5
      uart_auto   = 1'b0;
      ifc.tx_idle = 1'b0;
      base = txlog.size();
      for (int i = 0; i < 5; i++) push_byte(8'h50 + 8'(i));
      check("pp_level_pre", ifc.level, 5);
      ifc.tx_idle  = 1'b1;
      uart_auto    = 1'b1;
      ifc.in_byte  = 8'h5A;
      ifc.in_valid = 1'b1;
      tick();
      ifc.in_valid = 1'b0;
      check("pp_push", last_acc, 1);
      check("pp_req", ifc.tx_req, 1);
      check("pp_level", ifc.level, 5);
      wait_idle(200);
      check("pp_count", txlog.size() - base, 6);
      check("pp_sixth", txlog[base+5], 8'h5A);

      // Flush with a frame in flight
      uart_auto   = 1'b0;
      ifc.tx_idle = 1'b1;
      base = txlog.size();
      for (int i = 0; i < 5; i++) push_byte(8'h80 + 8'(i));
      for (int i = 0; i < 20; i++) begin
         if (txlog.size() > base) break;
         tick();
      end
      check("flush_first_req", txlog.size() - base, 1);
      ifc.tx_idle = 1'b0;
      tick();
      tick();
      check("flush_level_pre", ifc.level, 4);
      ifc.flush    = 1'b1;
      ifc.in_valid = 1'b1;
      ifc.in_byte  = 8'hEE;
      tick();
      ifc.flush    = 1'b0;
      ifc.in_valid = 1'b0;
      check("flush_level", ifc.level, 0);
      check("flush_drop", last_acc, 0);
      check("flush_inflight_busy", ifc.busy, 1);
      ifc.tx_idle = 1'b1;
      repeat (20) tick();
      check("flush_no_more_req", txlog.size() - base, 1);
      check("flush_busy_done", ifc.busy, 0);

      // Asynchronous reset in S_WAIT_BUSY with bytes queued
      base = txlog.size();
      for (int i = 0; i < 4; i++) push_byte(8'h90 + 8'(i));
      for (int i = 0; i < 20; i++) begin
         if (txlog.size() > base) break;
         tick();
      end
      check("rst_first_req", txlog.size() - base, 1);
      tick();
      tick();
      check("rst_level_pre", ifc.level, 3);
      check("rst_busy_pre", ifc.busy, 1);
      async_reset();
      repeat (20) tick();
      check("rst_no_more_req", txlog.size() - base, 1);
      check("rst_busy_after", ifc.busy, 0);

      // Randomized traffic with occasional flushes
      uart_auto   = 1'b1;
      uart_rand   = 1'b1;
      uart_cnt    = 0;
      ifc.tx_idle = 1'b1;
      for (int i = 0; i < 1500; i++) begin
         ifc.in_valid = ($urandom_range(0, 2) != 0);
         ifc.in_byte  = 8'($urandom);
         ifc.flush    = ($urandom_range(0, 63) == 0);
         tick();
      end
      ifc.in_valid = 1'b0;
      ifc.flush    = 1'b0;
      wait_idle(2000);
      check("rand_drained", mq.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/uart_tx_queue.md
UART_TX_QUEUE -- requirements
Module: uart_tx_queue

Interface
REQ-001 The block SHALL have parameter DEPTH, default 16, giving FIFO capacity in bytes; the value SHALL be a power of two, >= 2.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port in_byte, input, 8 bits: byte offered by the producer.
REQ-005 The block SHALL have port in_valid, input, 1 bit: in_byte is valid this cycle.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the queue accepts in_byte this cycle.
REQ-007 The block SHALL have port flush, input, 1 bit: synchronous discard of all queued bytes.
REQ-008 The block SHALL have port tx_byte, output, 8 bits: byte presented to the UART transmitter.
REQ-009 The block SHALL have port tx_req, output, 1 bit: one-cycle transmit request to the UART.
REQ-010 The block SHALL have port tx_idle, input, 1 bit: the UART transmitter is idle and samples tx_req.
REQ-011 The block SHALL have port level, output, $clog2(DEPTH)+1 bits: number of bytes currently queued.
REQ-012 The block SHALL have port busy, output, 1 bit: the queue is non-empty or a byte is in flight.

Function
REQ-013 in_ready SHALL equal (level != DEPTH) && !flush, decoded from registered state only, with no combinational path from in_valid.
REQ-014 A push SHALL occur on a rising edge where in_valid && in_ready; the byte is written at the write pointer, and the pointer advances modulo DEPTH.
REQ-015 Pointers SHALL be $clog2(DEPTH)+1 bits wide; full is indicated when the MSBs differ and the remaining bits are equal, and empty when the pointers are equal; wrap-around SHALL lose no data.
REQ-016 The drain FSM SHALL have four states: S_IDLE, S_REQ, S_WAIT_BUSY, S_WAIT_DONE.
REQ-017 In S_IDLE, when the FIFO is non-empty and tx_idle=1, the FSM SHALL load tx_byte from the head, pop the head in the same edge, and go to S_REQ.
REQ-018 In S_REQ, tx_req SHALL be 1 for exactly this one cycle, with tx_byte stable, and the FSM SHALL go to S_WAIT_BUSY.
REQ-019 In S_WAIT_BUSY, tx_req SHALL be 0, and the FSM SHALL remain until tx_idle=0, then go to S_WAIT_DONE.
REQ-020 In S_WAIT_DONE, the FSM SHALL remain until tx_idle=1, then go to S_IDLE; this guarantees at most one request per UART frame.
REQ-021 tx_req SHALL be registered, and tx_byte SHALL hold its value from load until the next load.
REQ-022 Latency: with an empty queue, the FSM in S_IDLE and tx_idle=1, a byte pushed at edge N SHALL give tx_req=1 in the cycle following edge N+2.
REQ-023 Simultaneous push and pop SHALL be legal; level is unchanged, and the pushed byte goes to the tail.
REQ-024 A pop SHALL never occur when the queue is empty, and a push SHALL never occur when it is full; in_valid while full is held off and the byte is not lost.
REQ-025 level SHALL increment on push-only, decrement on pop-only, and be unchanged otherwise; it SHALL never exceed DEPTH.
REQ-026 flush=1 at an edge SHALL reset both pointers and level to 0 and override any same-cycle push or pop.
REQ-027 flush SHALL NOT affect the FSM; a byte already loaded completes its S_REQ/S_WAIT sequence normally.
REQ-028 If flush coincides with an S_IDLE load, the load SHALL be suppressed and the FSM SHALL stay in S_IDLE.
REQ-029 busy SHALL equal (level != 0) || (state != S_IDLE).
REQ-030 Bytes SHALL be transmitted in strict FIFO order.

Reset
REQ-031 While rst=1, the block SHALL clear the pointers, set level=0, set the FSM to S_IDLE, and drive tx_req=0, tx_byte=8'h00 and busy=0; FIFO storage need not be cleared.
REQ-032 in_ready SHALL be 1 after rst deasserts, unless flush=1.
REQ-033 Assertion of rst mid-frame SHALL abandon the in-flight byte and all queued bytes, and no tx_req SHALL follow until new data is pushed.

Verification
REQ-034 Single byte: push 8'hA5 with tx_idle=1 -> tx_req is high for exactly 1 cycle, 2 edges after the push, with tx_byte=8'hA5 and level 1->0.
REQ-035 Pacing: push 8'h01, 8'h02 and 8'h03 back-to-back; model tx_idle going low the cycle after tx_req and staying low for 100 cycles -> exactly 3 tx_req pulses in the order 01, 02, 03, each only after tx_idle returns to 1.
REQ-036 Full/wrap: with tx_idle held 0 and DEPTH=16, push 0..16 -> the first 16 are accepted, in_ready=0 with level=16, and byte 16 is stalled; release tx_idle -> the output order is 0..16, including across pointer wrap.
REQ-037 Simultaneous push and pop: with level=5, push in the same cycle as the S_IDLE pop -> level stays 5, and the pushed byte leaves 6th.
REQ-038 Flush: with 4 bytes queued and one in S_WAIT_DONE, pulse flush together with in_valid -> level=0, the pushed byte is dropped, the in-flight frame completes, and there is no further tx_req.
REQ-039 Reset mid-operation: assert rst in S_WAIT_BUSY with 3 bytes queued -> tx_req=0, level=0 and busy=0 immediately (asynchronous), and there are no pulses after rst deasserts.
